// File: rtl/bsg_fifo_1r1w_small_multi.sv
// ---------------------------------------------------------------------------
// bsg_fifo_1r1w_small_multi
//
// Purpose:
//   chan_p independent FIFO queues of els_p entries each, kept in one shared
//   register file with one write port and one asynchronous read port. A
//   single enqueue port and a single dequeue port are each steered by a
//   channel index. This is typically used as virtual-channel buffering in
//   front of arbiters and NoC links. The depth els_p does not have to be a
//   power of two. Each channel reports its occupancy. A sticky flag records
//   any protocol violation.
//
// Ports:
//   clk_i          in   1            clock
//   reset_n_i      in   1            asynchronous active-low reset
//   v_i            in   1            enqueue valid
//   enq_chan_i     in   cw           enqueue channel index
//   data_i         in   width_p      enqueue data
//   ready_param_o  out  chan_p       per-channel not-full
//   v_o            out  chan_p       per-channel not-empty
//   deq_chan_i     in   cw           dequeue / read channel index
//   data_o         out  width_p      head of channel deq_chan_i (async read)
//   yumi_i         in   1            dequeue head of channel deq_chan_i
//   count_o        out  chan_p*nw    occupancy, channel c at [c*nw +: nw]
//   err_o          out  1            sticky protocol error
//
// Parameters:
//   width_p             data width in bits (>=1); the integrator must set it
//   els_p               entries per channel (>=2, any integer); must be set
//   chan_p              number of channels (>=1)
//   ready_THEN_valid_p  0 = valid-and-ready enqueue, 1 = ready-then-valid
// ---------------------------------------------------------------------------
module bsg_fifo_1r1w_small_multi #(
    parameter int width_p            = 8,
    parameter int els_p              = 4,
    parameter int chan_p             = 1,
    parameter int ready_THEN_valid_p = 0,
    localparam int cw = (chan_p > 1) ? $clog2(chan_p) : 1,
    localparam int nw = $clog2(els_p + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 v_i,
    input  logic [cw-1:0]        enq_chan_i,
    input  logic [width_p-1:0]   data_i,
    output logic [chan_p-1:0]    ready_param_o,
    output logic [chan_p-1:0]    v_o,
    input  logic [cw-1:0]        deq_chan_i,
    output logic [width_p-1:0]   data_o,
    input  logic                 yumi_i,
    output logic [chan_p*nw-1:0] count_o,
    output logic                 err_o
);

    localparam int pw    = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int depth = chan_p * els_p;
    localparam int aw    = (depth > 1) ? $clog2(depth) : 1;

    // Per-channel pointer and occupancy state. The storage array is
    // deliberately not reset.
    logic [pw-1:0]      wptr_r  [chan_p];
    logic [pw-1:0]      rptr_r  [chan_p];
    logic [nw-1:0]      count_r [chan_p];
    logic [pw-1:0]      wptr_n  [chan_p];
    logic [pw-1:0]      rptr_n  [chan_p];
    logic [nw-1:0]      count_n [chan_p];
    logic               err_r;
    logic               err_n;
    logic [width_p-1:0] mem [depth];

    // Channel index validation and the indices clamped into range.
    logic          enq_idx_ok;
    logic          deq_idx_ok;
    logic [cw-1:0] enq_sel;
    logic [cw-1:0] deq_sel;
    logic          enq_ready;
    logic          deq_valid;
    logic          enq;
    logic          deq;
    logic          err_now;
    logic [aw-1:0] wr_addr;
    logic [aw-1:0] rd_addr;

    // When chan_p is not a power of two, the index field can name a channel
    // that does not exist. Out-of-range indices are clamped to channel 0.
    // This keeps every array access legal. Any operation that uses such an
    // index is suppressed and flagged as an error.
    always_comb begin
        enq_idx_ok = (int'(enq_chan_i) < chan_p);
        deq_idx_ok = (int'(deq_chan_i) < chan_p);
        enq_sel    = enq_idx_ok ? enq_chan_i : '0;
        deq_sel    = deq_idx_ok ? deq_chan_i : '0;
    end

    // Status flags depend only on the registered counts. There is no
    // combinational path from v_i or yumi_i to these outputs.
    always_comb begin
        ready_param_o = '0;
        v_o           = '0;
        count_o       = '0;
        for (int c = 0; c < chan_p; c++) begin
            ready_param_o[c]     = (count_r[c] != nw'(els_p));
            v_o[c]               = (count_r[c] != '0);
            count_o[c*nw +: nw]  = count_r[c];
        end
    end

    // Transfer qualification. In both modes a write into a full channel
    // never happens. In ready-then-valid mode such an attempt is a protocol
    // error. In valid-and-ready mode it is simply not accepted.
    always_comb begin
        enq_ready = enq_idx_ok & ready_param_o[enq_sel];
        deq_valid = deq_idx_ok & v_o[deq_sel];
        enq       = v_i & enq_ready;
        deq       = yumi_i & deq_valid;
        err_now   = (yumi_i & ~deq_valid)
                  | ((ready_THEN_valid_p != 0) & v_i & ~enq_ready)
                  | (v_i & ~enq_idx_ok);
        err_n     = err_r | err_now;
    end

    // Flat storage addresses: channel base plus the per-channel pointer.
    always_comb begin
        wr_addr = aw'(int'(enq_sel) * els_p + int'(wptr_r[enq_sel]));
        rd_addr = aw'(int'(deq_sel) * els_p + int'(rptr_r[deq_sel]));
    end

    // Next-state pointers and counts. Pointers wrap at els_p-1 rather than
    // at a power of two. A channel that sees an enqueue and a dequeue in the
    // same cycle keeps its count.
    always_comb begin
        for (int c = 0; c < chan_p; c++) begin
            wptr_n[c]  = wptr_r[c];
            rptr_n[c]  = rptr_r[c];
            count_n[c] = count_r[c];
        end
        if (enq) begin
            wptr_n[enq_sel] = (wptr_r[enq_sel] == pw'(els_p - 1))
                            ? '0 : wptr_r[enq_sel] + pw'(1);
        end
        if (deq) begin
            rptr_n[deq_sel] = (rptr_r[deq_sel] == pw'(els_p - 1))
                            ? '0 : rptr_r[deq_sel] + pw'(1);
        end
        for (int c = 0; c < chan_p; c++) begin
            case ({enq && (enq_sel == cw'(c)), deq && (deq_sel == cw'(c))})
                2'b10:   count_n[c] = count_r[c] + nw'(1);
                2'b01:   count_n[c] = count_r[c] - nw'(1);
                default: count_n[c] = count_r[c];
            endcase
        end
    end

    // State registers. An asynchronous reset drops all queued data at once.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < chan_p; c++) begin
                wptr_r[c]  <= '0;
                rptr_r[c]  <= '0;
                count_r[c] <= '0;
            end
            err_r <= 1'b0;
        end else begin
            for (int c = 0; c < chan_p; c++) begin
                wptr_r[c]  <= wptr_n[c];
                rptr_r[c]  <= rptr_n[c];
                count_r[c] <= count_n[c];
            end
            err_r <= err_n;
        end
    end

    // Storage write. The read port is asynchronous and sees the new word
    // only after the edge. A same-cycle enqueue therefore never bypasses to
    // data_o.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wr_addr] <= data_i;
        end
    end

    assign data_o = mem[rd_addr];
    assign err_o  = err_r;

endmodule

// File: tb/tb_bsg_fifo_1r1w_small_multi.sv
// ---------------------------------------------------------------------------
// tb_bsg_fifo_1r1w_small_multi
//
// This bench drives two instances with directed vectors:
//   dut_a : chan_p=4, els_p=3, valid-and-ready enqueue
//   dut_b : chan_p=3, els_p=3, ready-then-valid enqueue. Index 3 is out of
//           range.
// Every expected value below is worked out by hand.
// ---------------------------------------------------------------------------
module tb_bsg_fifo_1r1w_small_multi;

    logic clk = 1'b0;

    logic       a_reset_n, a_v, a_yumi, a_err;
    logic [1:0] a_enq_chan, a_deq_chan;
    logic [7:0] a_data, a_data_o, a_count;
    logic [3:0] a_ready, a_vo;

    logic       b_reset_n, b_v, b_yumi, b_err;
    logic [1:0] b_enq_chan, b_deq_chan;
    logic [7:0] b_data, b_data_o;
    logic [5:0] b_count;
    logic [2:0] b_ready, b_vo;

    int checks = 0;
    int errors = 0;

    bsg_fifo_1r1w_small_multi #(
        .width_p(8), .els_p(3), .chan_p(4), .ready_THEN_valid_p(0)
    ) dut_a (
        .clk_i(clk), .reset_n_i(a_reset_n), .v_i(a_v), .enq_chan_i(a_enq_chan),
        .data_i(a_data), .ready_param_o(a_ready), .v_o(a_vo),
        .deq_chan_i(a_deq_chan), .data_o(a_data_o), .yumi_i(a_yumi),
        .count_o(a_count), .err_o(a_err)
    );

    bsg_fifo_1r1w_small_multi #(
        .width_p(8), .els_p(3), .chan_p(3), .ready_THEN_valid_p(1)
    ) dut_b (
        .clk_i(clk), .reset_n_i(b_reset_n), .v_i(b_v), .enq_chan_i(b_enq_chan),
        .data_i(b_data), .ready_param_o(b_ready), .v_o(b_vo),
        .deq_chan_i(b_deq_chan), .data_o(b_data_o), .yumi_i(b_yumi),
        .count_o(b_count), .err_o(b_err)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on instance a (sel=0) or b (sel=1). Outputs are
    // sampled 1 unit after the edge.
    task automatic applyStimulus(input bit sel, input bit v, input logic [1:0] ec,
                                 input logic [7:0] d, input bit y,
                                 input logic [1:0] dc);
        if (!sel) begin
            a_v = v; a_enq_chan = ec; a_data = d; a_yumi = y; a_deq_chan = dc;
        end else begin
            b_v = v; b_enq_chan = ec; b_data = d; b_yumi = y; b_deq_chan = dc;
        end
        @(posedge clk);
        #1;
        a_v = 1'b0; a_yumi = 1'b0;
        b_v = 1'b0; b_yumi = 1'b0;
    endtask

    initial begin
        a_v = 0; a_yumi = 0; a_enq_chan = 0; a_deq_chan = 0; a_data = 0;
        b_v = 0; b_yumi = 0; b_enq_chan = 0; b_deq_chan = 0; b_data = 0;
        a_reset_n = 1'b1;
        b_reset_n = 1'b1;
        #1;
        a_reset_n = 1'b0;
        b_reset_n = 1'b0;
        #2;
        checkOutput("rst_ready", a_ready, 4'hF);
        checkOutput("rst_vo", a_vo, 4'h0);
        checkOutput("rst_count", a_count, 8'h00);
        checkOutput("rst_err", a_err, 1'b0);
        checkOutput("rst_b_ready", b_ready, 3'b111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_reset_n = 1'b1;
        b_reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rel_ready", a_ready, 4'hF);

        // Fill channel 1 to capacity. The fourth valid must be ignored.
        applyStimulus(0, 1, 2'd1, 8'hA1, 0, 2'd1);
        applyStimulus(0, 1, 2'd1, 8'hA2, 0, 2'd1);
        applyStimulus(0, 1, 2'd1, 8'hA3, 0, 2'd1);
        checkOutput("full_count", a_count, 8'h0C);
        checkOutput("full_ready", a_ready, 4'b1101);
        applyStimulus(0, 1, 2'd1, 8'hA4, 0, 2'd1);
        checkOutput("full_ignore_cnt", a_count, 8'h0C);
        checkOutput("full_ignore_err", a_err, 1'b0);
        checkOutput("full_vo", a_vo, 4'b0010);
        checkOutput("full_head1", a_data_o, 8'hA1);
        applyStimulus(0, 0, 2'd0, 8'h00, 1, 2'd1);
        checkOutput("full_head2", a_data_o, 8'hA2);
        applyStimulus(0, 0, 2'd0, 8'h00, 1, 2'd1);
        checkOutput("full_head3", a_data_o, 8'hA3);
        applyStimulus(0, 0, 2'd0, 8'h00, 1, 2'd1);
        checkOutput("full_drained", a_count, 8'h00);

        // Run seven enqueue/dequeue pairs on channel 0. The pointers wrap
        // 2 -> 0 along the way.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 1, 2'd0, 8'(8'h50 + i), 0, 2'd0);
            checkOutput("wrap_vo", a_vo[0], 1'b1);
            checkOutput("wrap_data", a_data_o, 8'h50 + i);
            applyStimulus(0, 0, 2'd0, 8'h00, 1, 2'd0);
        end
        checkOutput("wrap_count", a_count, 8'h00);

        // Simultaneous enqueue and dequeue on one channel.
        applyStimulus(0, 1, 2'd0, 8'h60, 0, 2'd0);
        applyStimulus(0, 1, 2'd0, 8'h61, 0, 2'd0);
        applyStimulus(0, 1, 2'd0, 8'h62, 1, 2'd0);
        checkOutput("sim_count", a_count, 8'h02);
        checkOutput("sim_head", a_data_o, 8'h61);
        applyStimulus(0, 1, 2'd0, 8'h63, 0, 2'd0);
        checkOutput("sim_full_ready", a_ready, 4'b1110);
        applyStimulus(0, 1, 2'd0, 8'h64, 1, 2'd0);
        checkOutput("sim_full_count", a_count, 8'h02);
        checkOutput("sim_full_head", a_data_o, 8'h62);
        applyStimulus(0, 0, 2'd0, 8'h00, 1, 2'd0);
        checkOutput("sim_tail", a_data_o, 8'h63);
        applyStimulus(0, 0, 2'd0, 8'h00, 1, 2'd0);
        checkOutput("sim_empty", a_count, 8'h00);

        // Cross-channel isolation between channels 0 and 3.
        applyStimulus(0, 1, 2'd0, 8'h10, 0, 2'd3);
        applyStimulus(0, 1, 2'd3, 8'h30, 0, 2'd3);
        applyStimulus(0, 1, 2'd0, 8'h11, 0, 2'd3);
        checkOutput("iso_data3", a_data_o, 8'h30);
        checkOutput("iso_count", a_count, 8'h42);
        applyStimulus(0, 0, 2'd0, 8'h00, 1, 2'd3);
        checkOutput("iso_count2", a_count, 8'h02);
        a_deq_chan = 2'd0;
        #1;
        checkOutput("iso_head0", a_data_o, 8'h10);
        applyStimulus(0, 0, 2'd0, 8'h00, 1, 2'd0);
        checkOutput("iso_head1", a_data_o, 8'h11);
        applyStimulus(0, 0, 2'd0, 8'h00, 1, 2'd0);
        checkOutput("iso_empty", a_count, 8'h00);

        // A dequeue from empty channel 2 is an error. State must not change.
        checkOutput("err_pre", a_err, 1'b0);
        applyStimulus(0, 0, 2'd0, 8'h00, 1, 2'd2);
        checkOutput("err_set", a_err, 1'b1);
        checkOutput("err_count", a_count, 8'h00);
        checkOutput("err_ready", a_ready, 4'hF);
        applyStimulus(0, 0, 2'd0, 8'h00, 0, 2'd2);
        checkOutput("err_sticky", a_err, 1'b1);

        // Mid-traffic asynchronous reset clears everything at once.
        applyStimulus(0, 1, 2'd0, 8'h77, 0, 2'd0);
        applyStimulus(0, 1, 2'd1, 8'h78, 0, 2'd0);
        checkOutput("mid_pre_count", a_count, 8'h05);
        #2;
        a_reset_n = 1'b0;
        #1;
        checkOutput("mid_ready", a_ready, 4'hF);
        checkOutput("mid_vo", a_vo, 4'h0);
        checkOutput("mid_count", a_count, 8'h00);
        checkOutput("mid_err", a_err, 1'b0);
        @(negedge clk);
        a_reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Ready-then-valid instance: an out-of-range index is an error.
        applyStimulus(1, 1, 2'd3, 8'hEE, 0, 2'd0);
        checkOutput("rtv_idx_err", b_err, 1'b1);
        checkOutput("rtv_idx_count", b_count, 6'h00);
        b_reset_n = 1'b0;
        #1;
        checkOutput("rtv_rst_err", b_err, 1'b0);
        @(negedge clk);
        b_reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill channel 0, then push once more. This is an error and must not
        // overwrite anything.
        applyStimulus(1, 1, 2'd0, 8'hB1, 0, 2'd0);
        applyStimulus(1, 1, 2'd0, 8'hB2, 0, 2'd0);
        applyStimulus(1, 1, 2'd0, 8'hB3, 0, 2'd0);
        checkOutput("rtv_full_ready", b_ready, 3'b110);
        checkOutput("rtv_ok_err", b_err, 1'b0);
        applyStimulus(1, 1, 2'd0, 8'hBF, 0, 2'd0);
        checkOutput("rtv_ovf_err", b_err, 1'b1);
        checkOutput("rtv_ovf_count", b_count, 6'h03);
        checkOutput("rtv_head1", b_data_o, 8'hB1);
        applyStimulus(1, 0, 2'd0, 8'h00, 1, 2'd0);
        checkOutput("rtv_head2", b_data_o, 8'hB2);
        applyStimulus(1, 0, 2'd0, 8'h00, 1, 2'd0);
        checkOutput("rtv_head3", b_data_o, 8'hB3);
        applyStimulus(1, 0, 2'd0, 8'h00, 1, 2'd0);
        checkOutput("rtv_empty", b_vo, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
